// File: rtl/data_mem_hs_pkg.sv
// dmem_pkg -- shared definitions for the data_mem_hs data memory.
//   size_e          : request size encodings (byte / half / word / reserved)
//   align_off       : byte offset after force-alignment for the access size
//   misaligned      : true when the offset is not natural for the size
//   lane_enable     : 4-bit byte-lane write enable for a store
//   store_replicate : replicates right-aligned store data across all lanes
//   load_extend     : selects the loaded lane(s) and zero/sign-extends them
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   function automatic logic [1:0] align_off(size_e sz, logic [1:0] off);
      case (sz)
         SZ_HALF: return {off[1], 1'b0};
         SZ_WORD: return 2'b00;
         default: return off;
      endcase
   endfunction

   function automatic logic misaligned(size_e sz, logic [1:0] off);
      case (sz)
         SZ_HALF: return off[0];
         SZ_WORD: return (off != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_enable(size_e sz, logic [1:0] off);
      case (sz)
         SZ_BYTE: return 4'b0001 << off;
         SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_replicate(size_e sz, logic [31:0] wdata);
      case (sz)
         SZ_BYTE: return {4{wdata[7:0]}};
         SZ_HALF: return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(logic [31:0] word, size_e sz,
                                               logic [1:0] off, logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
         SZ_WORD: return word;
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// data_mem_hs_if -- valid/ready request and response channels of the data memory.
//   req_*  : request channel (valid, ready, store flag, byte address, size,
//            unsigned-load flag, right-aligned store data)
//   rsp_*  : response channel (valid, ready, extended load data, fault flag)
//   master : the requester side; slave : the memory side
interface data_mem_hs_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_bram_be.sv
// dmem_bram_be -- DEPTH x 32 storage with byte write enables and a registered read.
//   clk   : clock
//   en    : access enable; rdata only updates when set
//   we    : per-byte write enable (bit n covers bits 8n+7:8n)
//   addr  : word index
//   wdata : write data, already placed in its lanes
//   rdata : word read on the enabled edge; written lanes return the new data
module dmem_bram_be #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic [3:0]       we,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] merged;

   // Word as it will look after this edge's write, so the read is write-first
   always_comb begin
      merged = mem[addr];
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            merged[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   // Contents are intentionally never reset; rdata holds between accesses so a
   // stalled response stays stable
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         rdata <= merged;
      end
   end

endmodule

// File: rtl/data_mem_hs.sv
// data_mem_hs -- byte-addressable data memory behind a valid/ready handshake,
// one-cycle response latency for loads and stores.
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset (drops a pending response, keeps memory)
//   bus : data_mem_hs_if slave port (request and response channels)
// Build option: define DMEM_MISALIGN_ERR_EN to fault misaligned half/word
// accesses; otherwise they are force-aligned and complete without error.
module data_mem_hs
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   data_mem_hs_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W < IDX_W + 2) begin : g_bad_params
      $error("data_mem_hs: DEPTH must be a power of two >= 4 and ADDR_W >= log2(DEPTH)+2");
   end

   // Address bits above the array alias and are deliberately ignored
   if (ADDR_W > IDX_W + 2) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^bus.req_addr[ADDR_W-1:IDX_W+2];
   end

   size_e       req_sz;
   logic [1:0]  req_off;
   logic        req_err;
   logic        accept;
   logic [3:0]  mem_we;
   logic [31:0] mem_rdata;

   logic        rsp_valid_q;
   logic        rsp_load_q;
   logic        rsp_err_q;
   size_e       rsp_size_q;
   logic [1:0]  rsp_off_q;
   logic        rsp_uns_q;

   assign req_sz  = size_e'(bus.req_size);
   assign req_off = align_off(req_sz, bus.req_addr[1:0]);

`ifdef DMEM_MISALIGN_ERR_EN
   assign req_err = (req_sz == SZ_RSVD) || misaligned(req_sz, bus.req_addr[1:0]);
`else
   assign req_err = (req_sz == SZ_RSVD);
`endif

   // A new request may enter in the same cycle the current response retires;
   // reset blocks acceptance even though ready may read high
   assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
   assign accept        = bus.req_valid && bus.req_ready && !rst;
   assign mem_we        = (accept && bus.req_we && !req_err) ? lane_enable(req_sz, req_off) : 4'b0000;

   dmem_bram_be #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_bram (
      .clk   (clk),
      .en    (accept),
      .we    (mem_we),
      .addr  (bus.req_addr[IDX_W+1:2]),
      .wdata (store_replicate(req_sz, bus.req_wdata)),
      .rdata (mem_rdata)
   );

   // Response register: captures what is needed to shape the load data one
   // cycle later, and holds it while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_load_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_size_q  <= SZ_WORD;
         rsp_off_q   <= 2'b00;
         rsp_uns_q   <= 1'b0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_load_q  <= !bus.req_we;
         rsp_err_q   <= req_err;
         rsp_size_q  <= req_sz;
         rsp_off_q   <= req_off;
         rsp_uns_q   <= bus.req_unsigned;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_valid_q && rsp_err_q;
   assign bus.rsp_rdata = (rsp_valid_q && rsp_load_q && !rsp_err_q)
                          ? load_extend(mem_rdata, rsp_size_q, rsp_off_q, rsp_uns_q)
                          : 32'h0;

endmodule

// File: tb/tb_data_mem_hs.sv
// tb_data_mem_hs -- scoreboard testbench for data_mem_hs.
// A byte-level reference memory predicts every response when the request is
// accepted; responses are popped and compared as they retire.
module tb_data_mem_hs;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 32;
`ifdef DMEM_MISALIGN_ERR_EN
   localparam bit MISALIGN_ERR = 1'b1;
`else
   localparam bit MISALIGN_ERR = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         checks = 0;
   int         errors = 0;
   bit         randomReady = 1'b0;
   exp_t       sb[$];
   logic [7:0] modelMem [DEPTH*4];

   data_mem_hs_if #(.ADDR_W(ADDR_W)) bus ();

   data_mem_hs #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Counts one comparison and reports it when it does not match
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour at byte granularity, pushed at acceptance
   task automatic modelAccess(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata);
      exp_t        e;
      int          nbytes;
      int          a;
      logic [31:0] val;
      e.data = 32'h0;
      e.err  = 1'b0;
      nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      a      = int'(addr & 32'(DEPTH*4 - 1));
      if (size == 2'b11) begin
         e.err = 1'b1;
      end else if (MISALIGN_ERR && (a % nbytes) != 0) begin
         e.err = 1'b1;
      end else begin
         a = a - (a % nbytes);
         if (we) begin
            for (int k = 0; k < nbytes; k++) modelMem[a+k] = wdata[8*k +: 8];
         end else begin
            val = 32'h0;
            for (int k = 0; k < nbytes; k++) val[8*k +: 8] = modelMem[a+k];
            if (!uns && val[8*nbytes-1]) begin
               for (int k = nbytes; k < 4; k++) val[8*k +: 8] = 8'hFF;
            end
            e.data = val;
         end
      end
      sb.push_back(e);
   endtask

   // Presents one request and returns just after the edge that accepts it
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata);
      int waitCycles = 0;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_addr     = addr;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_wdata    = wdata;
      #3;
      while (!bus.req_ready && waitCycles < 100) begin
         @(negedge clk);
         #3;
         waitCycles++;
      end
      if (!bus.req_ready) begin
         checkOutput("req_ready_timeout", 32'(bus.req_ready), 32'h1);
         bus.req_valid = 1'b0;
      end else begin
         modelAccess(we, addr, size, uns, wdata);
         @(posedge clk);
         #1;
         bus.req_valid = 1'b0;
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      exp_t e;
      #3;
      if (bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) begin
            checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
         end else begin
            e = sb.pop_front();
            checkOutput("rsp_rdata", bus.rsp_rdata, e.data);
            checkOutput("rsp_err", 32'(bus.rsp_err), 32'(e.err));
         end
      end
   end

   // Random back-pressure during the random phase
   always @(negedge clk) begin
      if (randomReady) bus.rsp_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      int w;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_addr     = '0;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_wdata    = 32'h0;
      bus.rsp_ready    = 1'b1;

      // Reset state
      repeat (3) begin
         @(negedge clk);
         #3;
         checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
         checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
         checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      #3;
      checkOutput("ready_after_rst", 32'(bus.req_ready), 32'h1);

      // Fill the memory so every later load has a known value
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(i*4), 2'b10, 1'b0, $urandom);

      // Word store/load and one-cycle latency
      applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
      applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      @(negedge clk);
      #3;
      checkOutput("load_latency", 32'(bus.rsp_valid), 32'h1);

      // Signed/unsigned byte and half loads
      applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'h00000000);
      applyStimulus(1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080);
      applyStimulus(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
      applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h22, 2'b01, 1'b0, 32'h12348001);
      applyStimulus(1'b0, 32'h22, 2'b01, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h22, 2'b01, 1'b1, 32'h0);

      // Misaligned accesses (faulted or force-aligned depending on the build)
      applyStimulus(1'b0, 32'h2, 2'b01, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h3, 2'b01, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h5, 2'b10, 1'b0, 32'hCAFEF00D);
      applyStimulus(1'b0, 32'h4, 2'b10, 1'b0, 32'h0);

      // Back-pressure: response held for 3 cycles, then back-to-back acceptance
      applyStimulus(1'b1, 32'h30, 2'b10, 1'b0, 32'h5A5AA5A5);
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      applyStimulus(1'b0, 32'h30, 2'b10, 1'b0, 32'h0);
      fork
         applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
         begin
            repeat (3) begin
               @(negedge clk);
               #3;
               checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 32'h1);
               checkOutput("stall_req_ready", 32'(bus.req_ready), 32'h0);
               checkOutput("stall_rsp_rdata", bus.rsp_rdata, 32'h5A5AA5A5);
               checkOutput("stall_rsp_err", 32'(bus.rsp_err), 32'h0);
            end
            @(negedge clk);
            bus.rsp_ready = 1'b1;
         end
      join

      // Reset with a store response pending; also a store presented during reset
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      applyStimulus(1'b1, 32'h40, 2'b10, 1'b0, 32'h12345678);
      @(negedge clk);
      rst              = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b1;
      bus.req_addr     = 32'h44;
      bus.req_size     = 2'b10;
      bus.req_wdata    = 32'hBAD0BAD0;
      @(negedge clk);
      #3;
      checkOutput("rst_drop_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("rst_drop_err", 32'(bus.rsp_err), 32'h0);
      checkOutput("rst_drop_rdata", bus.rsp_rdata, 32'h0);
      if (sb.size() != 0) void'(sb.pop_front());
      @(negedge clk);
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      #3;
      checkOutput("ready_after_rst2", 32'(bus.req_ready), 32'h1);
      applyStimulus(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h44, 2'b10, 1'b0, 32'h0);

      // Reserved size faults and does not write
      applyStimulus(1'b1, 32'h40, 2'b11, 1'b0, 32'hFFFFFFFF);
      applyStimulus(1'b0, 32'h40, 2'b11, 1'b1, 32'h0);
      applyStimulus(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);

      // Address aliasing above the array
      applyStimulus(1'b1, 32'(DEPTH*4 + 'h10), 2'b10, 1'b0, 32'h0BADCAFE);
      applyStimulus(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'(DEPTH*4 + 'h13), 2'b00, 1'b1, 32'h0);

      // Random traffic with random back-pressure
      randomReady = 1'b1;
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom);
      end
      randomReady   = 1'b0;
      bus.rsp_ready = 1'b1;

      w = 0;
      while (sb.size() != 0 && w < 20) begin
         @(negedge clk);
         #4;
         w++;
      end
      checkOutput("drain_empty", 32'(sb.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_hs.md
DATA_MEM_HS -- requirements
Module: data_mem_hs

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words; it SHALL be a power of two, at least 4.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width; it SHALL be at least log2(DEPTH)+2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-009 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-010 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-011 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-014 The block SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: the access faulted.

Function
REQ-016 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1.
REQ-017 req_ready SHALL equal !rsp_valid || rsp_ready, so a new request is accepted in the same cycle the pending response retires.
REQ-018 Every accepted request SHALL produce exactly one response, with rsp_valid=1 on the cycle after acceptance (latency 1), loads and stores alike.
REQ-019 While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_rdata and rsp_err SHALL hold stable and no request SHALL be accepted.
REQ-020 rsp_valid SHALL clear after the handshake unless a new request is accepted in the same cycle.
REQ-021 The word index SHALL be req_addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so accesses alias modulo DEPTH*4 bytes.
REQ-022 Store lane enables SHALL be:
- byte: 1 << addr[1:0]
- half: 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1
- word: 4'b1111
REQ-023 Store data SHALL be replicated across lanes: byte as {4{wdata[7:0]}}, half as {2{wdata[15:0]}}.
REQ-024 The store SHALL commit on the acceptance edge; only enabled lanes change.
REQ-025 A load SHALL read the array on the acceptance edge into a registered word.
REQ-026 The load response SHALL select the lane(s) given by the latched addr[1:0] and size, then extend them to 32 bits per the latched req_unsigned.
REQ-027 A load accepted on the cycle after a store to the same word SHALL return the post-store data.
REQ-028 req_size=11 SHALL produce rsp_err=1 and rsp_rdata=0, with no array write.

Reset
REQ-029 While rst=1: rsp_valid=0, rsp_err=0, rsp_rdata=0, and req_ready=1 on the first cycle after rst deasserts.
REQ-030 Array contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted while a response is pending SHALL drop that response; a store already committed SHALL remain committed.
REQ-032 No request SHALL be accepted and no write SHALL occur while rst=1.

Configuration
REQ-033 With macro DMEM_MISALIGN_ERR_EN defined, a misaligned half (addr[0]=1) or word (addr[1:0]!=0) access SHALL produce rsp_err=1 and rsp_rdata=0, with no array write.
REQ-034 Without DMEM_MISALIGN_ERR_EN, misaligned accesses SHALL be force-aligned by ignoring addr[0] for half and addr[1:0] for word, with rsp_err=0.

Structure
REQ-035 Package dmem_pkg SHALL hold:
- size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
- the lane-enable function
- the load-extend function
REQ-036 The storage SHALL be a sub-module dmem_bram_be: a DEPTH x 32 array with a 4-bit byte write-enable and synchronous read, with read-after-write returning new data.
REQ-037 The handshake, lane logic and response register SHALL reside in data_mem_hs.

Verification
REQ-038 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after acceptance.
REQ-039 Store byte 0x80 at 0x13 over 0x00000000, then load byte signed at 0x13 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word at 0x10 -> 0x80000000.
REQ-040 Hold rsp_ready=0 for 3 cycles after a load -> rsp_* held stable, req_ready=0; raise rsp_ready with req_valid=1 -> back-to-back acceptance, no lost or duplicated response.
REQ-041 Load half at 0x2 with DMEM_MISALIGN_ERR_EN defined -> rsp_err=0; load half at 0x3 -> rsp_err=1, rsp_rdata=0; store word at 0x5 -> rsp_err=1, memory unchanged.
REQ-042 Assert rst while rsp_valid=1 -> rsp_valid=0 next cycle, array data preserved; req_size=11 -> rsp_err=1.
REQ-043 Access address DEPTH*4+0x10 -> aliases to 0x10.
